// File: rtl/cordic_iter_engine_if.sv
// ============================================================================
// cordic_iter_engine_if : valid/ready operand and result bundle for the engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface cordic_iter_engine_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_out;
  logic                busy;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );
endinterface

`default_nettype wire

// File: rtl/cordic_iter_engine.sv
// ============================================================================
// cordic_iter_engine : folded CORDIC, one add/shift datapath, ITER_NUM steps
// Optional gain compensation stage: define CORDIC_GAIN_COMP_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module cordic_iter_engine #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int ITER_NUM  = 14
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  cordic_iter_engine_if.slave bus
);

  localparam int W            = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int CNT_W        = $clog2(ITER_NUM) + 1;
  localparam int ROM_SHIFT    = 30 - DEC_WIDTH;
  localparam int ROM_SHIFT_M1 = (ROM_SHIFT > 0) ? ROM_SHIFT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef CORDIC_GAIN_COMP_EN
  localparam state_t AFTER_RUN = COMP;
  localparam logic signed [W-1:0] KINV =
    W'($rtoi(0.6072529350 * (2.0 ** DEC_WIDTH) + 0.5));
`else
  localparam state_t AFTER_RUN = DONE;
`endif

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                mode_q;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] z;
  logic                dir;
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic signed [W-1:0] atan_cur;
  logic signed [W-1:0] x_it;
  logic signed [W-1:0] y_it;
  logic signed [W-1:0] z_it;

  // atan(2^-i) in Q30, rescaled to DEC_WIDTH fraction bits with round-half-up
  function automatic logic signed [W-1:0] atan_rom(input int i);
    logic [31:0] q30;
    case (i)
      0:       q30 = 32'd843314857;
      1:       q30 = 32'd497837829;
      2:       q30 = 32'd263043837;
      3:       q30 = 32'd133525159;
      4:       q30 = 32'd67021687;
      5:       q30 = 32'd33543516;
      6:       q30 = 32'd16775851;
      7:       q30 = 32'd8388437;
      8:       q30 = 32'd4194283;
      9:       q30 = 32'd2097149;
      10:      q30 = 32'd1048576;
      11:      q30 = 32'd524288;
      12:      q30 = 32'd262144;
      13:      q30 = 32'd131072;
      14:      q30 = 32'd65536;
      15:      q30 = 32'd32768;
      default: q30 = 32'd0;
    endcase
    if (ROM_SHIFT > 0) q30 = (q30 + (32'd1 << ROM_SHIFT_M1)) >> ROM_SHIFT;
    return W'(q30);
  endfunction

  // Rotation steers z toward zero (negative z takes the d=1 branch);
  // vectoring steers y toward zero.
  always_comb begin
    dir      = mode_q ? z[W-1] : ~(x[W-1] ^ y[W-1]);
    x_sh     = x >>> cnt;
    y_sh     = y >>> cnt;
    atan_cur = atan_rom(int'(cnt));
    if (dir) begin
      x_it = x + y_sh;
      y_it = y - x_sh;
      z_it = z + atan_cur;
    end else begin
      x_it = x - y_sh;
      y_it = y + x_sh;
      z_it = z - atan_cur;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [2*W-1:0] x_wide;
  logic signed [2*W-1:0] y_wide;
  logic signed [2*W-1:0] k_wide;
  logic signed [W-1:0]   x_comp;
  logic signed [W-1:0]   y_comp;

  always_comb begin
    x_wide = {{W{x[W-1]}}, x};
    y_wide = {{W{y[W-1]}}, y};
    k_wide = {{W{KINV[W-1]}}, KINV};
    x_comp = W'((x_wide * k_wide) >>> DEC_WIDTH);
    y_comp = W'((y_wide * k_wide) >>> DEC_WIDTH);
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(ITER_NUM - 1)) state_nx = AFTER_RUN;
      COMP:    state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x      <= bus.x_in;
            y      <= bus.y_in;
            z      <= bus.z_in;
            mode_q <= bus.mode;
            cnt    <= '0;
          end
        end
        RUN: begin
          x   <= x_it;
          y   <= y_it;
          z   <= z_it;
          cnt <= cnt + CNT_W'(1);
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x <= x_comp;
          y <= y_comp;
        end
`endif
        default: ;
      endcase
    end
  end

  // Working registers only change in IDLE-accept/RUN/COMP, so they double as
  // the held result in DONE.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.x_out     = x;
  assign bus.y_out     = y;
  assign bus.z_out     = z;

endmodule

`default_nettype wire
